cook_sequencer: RTL

//  Microwave cook-cycle sequencer. Owns the MM:SS BCD cook timer, key entry and

---
 rtl/cook_sequencer_if.sv | 22 ++
 rtl/cook_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/cook_sequencer_if.sv
// cook_if: panel-side bundle for cook_sequencer, covering buttons, keypad, door
// and the magnetron/display/buzzer outputs.
interface cook_if;
   logic        startn;
   logic        stopn;
   logic        clearn;
   logic        door_closed;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        mag_on;
   logic        done_beep;
   logic [15:0] time_bcd;
   logic [2:0]  state;
   modport master (
      output startn, stopn, clearn, door_closed, digit_valid, digit,
      input  mag_on, done_beep, time_bcd, state
   );
   modport slave (
      input  startn, stopn, clearn, door_closed, digit_valid, digit,
      output mag_on, done_beep, time_bcd, state
   );
endinterface

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook-cycle sequencer with MM:SS BCD countdown,
// key entry, pause/resume and an end-of-cycle beep.
module cook_sequencer #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int BEEP_SECS     = 3
) (
   input logic   clk,
   input logic   resetn,
   cook_if.slave bus
);
   localparam int PW = $clog2(TICKS_PER_SEC + 1);
   localparam int BW = $clog2(BEEP_SECS + 1);
   localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BEEP_SECS - 1);
   typedef enum logic [2:0] {IDLE = 3'd0, COOK = 3'd1, PAUSE = 3'd2, DONE = 3'd3} state_t;
   state_t        st;
   logic [2:0]    s1, s2, s3;
   logic [15:0]   t, t_dec;
   logic [PW-1:0] pre;
   logic [BW-1:0] beeps;
   logic          beep, start_p, stop_p, clear_p, tick, b0, b1, b2;
   // Chains reset to the pressed level so a button held through reset never pulses.
   assign {start_p, stop_p, clear_p} = s3 & ~s2;
   assign tick = pre == P_LAST;
   assign b0 = t[3:0] == 4'd0;
   assign b1 = b0 & (t[7:4] == 4'd0);
   assign b2 = b1 & (t[11:8] == 4'd0);
   assign t_dec[3:0]   = b0 ? 4'd9 : t[3:0] - 4'd1;
   assign t_dec[7:4]   = !b0 ? t[7:4] : b1 ? 4'd5 : t[7:4] - 4'd1;
   assign t_dec[11:8]  = !b1 ? t[11:8] : b2 ? 4'd9 : t[11:8] - 4'd1;
   assign t_dec[15:12] = b2 ? t[15:12] - 4'd1 : t[15:12];
   assign bus.mag_on    = (st == COOK) & bus.door_closed;
   assign bus.done_beep = beep;
   assign bus.time_bcd  = t;
   assign bus.state     = st;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1    <= '0;
         s2    <= '0;
         s3    <= '0;
         st    <= IDLE;
         t     <= '0;
         pre   <= '0;
         beeps <= '0;
         beep  <= 1'b0;
      end else begin
         s1 <= {bus.startn, bus.stopn, bus.clearn};
         s2 <= s1;
         s3 <= s2;
         case (st)
            COOK:
               if (clear_p) begin
                  st <= IDLE;
                  t  <= '0;
               end else if (stop_p || !bus.door_closed) begin
                  st <= PAUSE;
               end else begin
                  pre <= tick ? '0 : pre + 1'b1;
                  if (tick) begin
                     t <= t_dec;
                     if (t_dec == 16'd0) begin
                        st    <= DONE;
                        beep  <= 1'b1;
                        beeps <= '0;
                     end
                  end
               end
            PAUSE:
               if (clear_p || stop_p) begin
                  st <= IDLE;
                  t  <= '0;
               end else if (start_p && bus.door_closed) begin
                  st <= COOK;
               end
            DONE:
               if (start_p || stop_p || clear_p) begin
                  st   <= IDLE;
                  beep <= 1'b0;
               end else begin
                  pre <= tick ? '0 : pre + 1'b1;
                  if (tick) begin
                     beeps <= beeps + 1'b1;
                     if (beeps == B_LAST) begin
                        st   <= IDLE;
                        beep <= 1'b0;
                     end
                  end
               end
            default: begin
               st <= IDLE;
               if (clear_p) t <= '0;
               else if (start_p && bus.door_closed && t != 16'd0) begin
                  st  <= COOK;
                  pre <= '0;
               end else if (bus.digit_valid && bus.digit <= 4'd9) t <= {t[11:0], bus.digit};
            end
         endcase
      end
   end
endmodule
